tdm_demux_1_to_8: RTL

Time-division 1-to-8 demultiplexer: the receive end of the 8-to-1 slot-multiplexed link. It takes one slot of data per valid beat from the serial lane, aligns to a frame-sync marker, and steers each slot into its channel position. It presents each completed 8-slot frame as a parallel word with a valid/ready handshake. It sits between the serial lane and the per-channel consumers in the mux/demux datapath.

---
 rtl/tdm_demux_1_to_8.sv | 109 ++++++++++
 1 files changed

// File: rtl/tdm_demux_1_to_8.sv
// Receive side of the 8-slot TDM link: aligns on frame sync, gathers eight slots
// into a shadow frame and hands completed frames out through a valid/ready register.
module tdm_demux_1_to_8 #(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DATA_W-1:0]        d_i,
  input  logic                     d_valid_i,
  input  logic                     sync_i,
  input  logic                     clr_i,
  output logic [NUM_CH*DATA_W-1:0] y_o,
  output logic                     y_valid_o,
  input  logic                     y_ready_i,
  output logic [2:0]               sel_o,
  output logic                     sync_err_o,
  output logic                     ovf_o
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

  state_t                     state;
  logic [DATA_W-1:0]          shadow [0:NUM_CH-1];
  logic [NUM_CH*DATA_W-1:0]   frame_word;

  logic       in_collect;
  logic       slot_wr;
  logic [2:0] wr_idx;
  logic       frame_done;
  logic       out_free;
  logic       load;
  logic       early_sync;
  logic       missing_sync;
  logic       err_set;
  logic       ovf_set;

  assign in_collect   = (state == COLLECT);
  assign slot_wr      = d_valid_i && (sync_i || (in_collect && sel_o != 3'd0));
  assign wr_idx       = sync_i ? 3'd0 : sel_o;
  assign frame_done   = d_valid_i && in_collect && !sync_i && (sel_o == LAST_SLOT);
  assign out_free     = !y_valid_o || y_ready_i;
  assign load         = frame_done && out_free;
  assign early_sync   = d_valid_i && in_collect && sync_i && (sel_o != 3'd0);
  assign missing_sync = d_valid_i && in_collect && !sync_i && (sel_o == 3'd0);
  assign err_set      = early_sync || missing_sync;
  assign ovf_set      = frame_done && !out_free;

  // The last slot bypasses the shadow so the frame loads on the edge sampling it.
  generate
    for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_pack
      assign frame_word[gi*DATA_W +: DATA_W] = shadow[gi];
    end
  endgenerate
  assign frame_word[(NUM_CH-1)*DATA_W +: DATA_W] = d_i;

  always_ff @(posedge clk_i) begin
    if (slot_wr) shadow[wr_idx] <= d_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= HUNT;
      sel_o      <= 3'd0;
      y_o        <= '0;
      y_valid_o  <= 1'b0;
      sync_err_o <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (d_valid_i && sync_i) begin
            sel_o <= 3'd1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (d_valid_i) begin
            if (sync_i) begin
              sel_o <= 3'd1;
            end else if (sel_o == 3'd0) begin
              state <= HUNT;
            end else begin
              sel_o <= sel_o + 3'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase

      if (load) begin
        y_o       <= frame_word;
        y_valid_o <= 1'b1;
      end else if (y_valid_o && y_ready_i) begin
        y_valid_o <= 1'b0;
      end

      // A new error in the clearing cycle must not be lost.
      if (err_set)    sync_err_o <= 1'b1;
      else if (clr_i) sync_err_o <= 1'b0;

      if (ovf_set)    ovf_o <= 1'b1;
      else if (clr_i) ovf_o <= 1'b0;
    end
  end

endmodule
